// File: rtl/semaforo_driver.sv
// Traffic-light lamp driver: decodes vehicle/pedestrian light codes into registered lamp outputs.
// Optional power-on lamp test is compiled in with SEMAFORO_DRIVER_LAMP_TEST_EN.
module semaforo_driver #(
  parameter logic [31:0] BLINK_HALF       = 32'd25000000,
  parameter logic [31:0] LAMP_TEST_CYCLES = 32'd50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] semaforo0,
  input  logic [2:0] semaforo1,
  input  logic [2:0] semaforo2,
  input  logic [2:0] semaforo3,
  input  logic [1:0] peatonal,
  output logic [3:0] lamp0,
  output logic [3:0] lamp1,
  output logic [3:0] lamp2,
  output logic [3:0] lamp3,
  output logic [1:0] ped_lamp,
  output logic       fault,
  output logic       blink_phase,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    LAMP_TEST = 2'd0,
    RUN       = 2'd1,
    FAULT     = 2'd2
  } state_t;

`ifdef SEMAFORO_DRIVER_LAMP_TEST_EN
  localparam state_t RESET_STATE = LAMP_TEST;
  localparam logic [31:0] LT_LAST = LAMP_TEST_CYCLES - 32'd1;
  logic [31:0] test_cnt;
`else
  localparam state_t RESET_STATE = RUN;
  wire unused_lamp_test_cycles = ^LAMP_TEST_CYCLES;
`endif

  localparam logic [31:0] BLINK_LAST = BLINK_HALF - 32'd1;

  state_t      state;
  logic [31:0] blink_cnt;
  logic        blink_wrap;
  logic        phase_nxt;
  logic        illegal;

  assign state_dbg  = state;
  assign blink_wrap = (blink_cnt == BLINK_LAST);
  // Lamps are loaded with the phase being registered on the same edge,
  // so a wrap and a code change land together without a stale-phase cycle.
  assign phase_nxt  = blink_wrap ? ~blink_phase : blink_phase;
  assign illegal    = (&semaforo0) | (&semaforo1) | (&semaforo2) |
                      (&semaforo3) | (&peatonal);

  function automatic logic [3:0] veh(input logic [2:0] code, input logic p);
    case (code)
      3'b000:  veh = 4'b0011;
      3'b001:  veh = {3'b001, p};
      3'b010:  veh = {2'b00, p, p};
      3'b011:  veh = 4'b0010;
      3'b100:  veh = {2'b00, p, 1'b0};
      3'b101:  veh = 4'b0100;
      3'b110:  veh = 4'b1000;
      default: veh = 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] ped(input logic [1:0] code, input logic p);
    case (code)
      2'b00:   ped = 2'b01;
      2'b01:   ped = {1'b0, p};
      2'b10:   ped = 2'b10;
      default: ped = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= 32'd0;
      blink_phase <= 1'b1;
    end else begin
      blink_cnt   <= blink_wrap ? 32'd0 : blink_cnt + 32'd1;
      blink_phase <= phase_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RESET_STATE;
      lamp0    <= 4'b1000;
      lamp1    <= 4'b1000;
      lamp2    <= 4'b1000;
      lamp3    <= 4'b1000;
      ped_lamp <= 2'b10;
      fault    <= 1'b0;
`ifdef SEMAFORO_DRIVER_LAMP_TEST_EN
      test_cnt <= 32'd0;
`endif
    end else begin
      case (state)
`ifdef SEMAFORO_DRIVER_LAMP_TEST_EN
        LAMP_TEST: begin
          lamp0    <= 4'b1111;
          lamp1    <= 4'b1111;
          lamp2    <= 4'b1111;
          lamp3    <= 4'b1111;
          ped_lamp <= 2'b11;
          test_cnt <= test_cnt + 32'd1;
          if (test_cnt == LT_LAST) state <= RUN;
        end
`endif
        RUN: begin
          if (illegal) begin
            state    <= FAULT;
            fault    <= 1'b1;
            lamp0    <= {1'b0, phase_nxt, 2'b00};
            lamp1    <= {1'b0, phase_nxt, 2'b00};
            lamp2    <= {1'b0, phase_nxt, 2'b00};
            lamp3    <= {1'b0, phase_nxt, 2'b00};
            ped_lamp <= 2'b00;
          end else begin
            lamp0    <= veh(semaforo0, phase_nxt);
            lamp1    <= veh(semaforo1, phase_nxt);
            lamp2    <= veh(semaforo2, phase_nxt);
            lamp3    <= veh(semaforo3, phase_nxt);
            ped_lamp <= ped(peatonal, phase_nxt);
          end
        end
        default: begin
          // FAULT: flashing amber everywhere until reset.
          state    <= FAULT;
          fault    <= 1'b1;
          lamp0    <= {1'b0, phase_nxt, 2'b00};
          lamp1    <= {1'b0, phase_nxt, 2'b00};
          lamp2    <= {1'b0, phase_nxt, 2'b00};
          lamp3    <= {1'b0, phase_nxt, 2'b00};
          ped_lamp <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_semaforo_driver.sv
// Directed bench for semaforo_driver with BLINK_HALF=4, LAMP_TEST_CYCLES=8;
// expectations follow SEMAFORO_DRIVER_LAMP_TEST_EN when it is defined.
module tb_semaforo_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] semaforo0 = 3'b000;
  logic [2:0] semaforo1 = 3'b000;
  logic [2:0] semaforo2 = 3'b000;
  logic [2:0] semaforo3 = 3'b000;
  logic [1:0] peatonal  = 2'b10;
  logic [3:0] lamp0, lamp1, lamp2, lamp3;
  logic [1:0] ped_lamp;
  logic       fault, blink_phase;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  int edges = 0;
  logic [19:0] exp_q[$];

  localparam logic [1:0]  ST_LT    = 2'd0;
  localparam logic [1:0]  ST_RUN   = 2'd1;
  localparam logic [1:0]  ST_FAULT = 2'd2;
  localparam logic [19:0] RST_OUT  = {16'h8888, 2'b10, 1'b0, 1'b1};
`ifdef SEMAFORO_DRIVER_LAMP_TEST_EN
  localparam logic [1:0]  RST_STATE = ST_LT;
`else
  localparam logic [1:0]  RST_STATE = ST_RUN;
`endif

  typedef struct {
    logic [2:0]  s0, s1, s2, s3;
    logic [1:0]  pd;
    logic [15:0] lamps;
    logic [1:0]  pl;
  } vec_t;
  vec_t tbl[8];

  semaforo_driver #(.BLINK_HALF(32'd4), .LAMP_TEST_CYCLES(32'd8)) dut (
    .clk(clk), .rst(rst),
    .semaforo0(semaforo0), .semaforo1(semaforo1),
    .semaforo2(semaforo2), .semaforo3(semaforo3),
    .peatonal(peatonal),
    .lamp0(lamp0), .lamp1(lamp1), .lamp2(lamp2), .lamp3(lamp3),
    .ped_lamp(ped_lamp), .fault(fault), .blink_phase(blink_phase),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [19:0] outs();
    return {lamp0, lamp1, lamp2, lamp3, ped_lamp, fault, blink_phase};
  endfunction

  // Blink phase after e edges since reset release: 1 for edges 0..3, 0 for 4..7, ...
  function automatic logic ph_at(input int e);
    return ((e / 4) % 2) == 0;
  endfunction

  function automatic logic [19:0] fault_pack(input logic p);
    return {{4{{1'b0, p, 2'b00}}}, 2'b00, 1'b1, p};
  endfunction

  function automatic logic [19:0] test_pack(input logic p);
    return {16'hFFFF, 2'b11, 1'b0, p};
  endfunction

  // driver tasks
  task automatic set_in(input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [2:0] d,
                        input logic [1:0] pd);
    semaforo0 = a; semaforo1 = b; semaforo2 = c; semaforo3 = d; peatonal = pd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
    end
  endtask

  // Called at posedge+1: rst rises between edges and is checked before any clock edge.
  task automatic async_reset(input string name);
    #2 rst = 1'b1;
    #1;
    check({name, "_outs"}, outs(), RST_OUT);
    check({name, "_state"}, {18'd0, state_dbg}, {18'd0, RST_STATE});
    #2 rst = 1'b0;
    edges = 0;
  endtask

  initial begin
    tbl[0] = '{3'b000, 3'b011, 3'b010, 3'b110, 2'b10, 16'b0011_0010_0011_1000, 2'b10};
`ifdef SEMAFORO_DRIVER_LAMP_TEST_EN
    tbl[0].s0 = 3'b110;
    tbl[0].lamps[15:12] = 4'b1000;
`endif
    tbl[1] = '{3'b001, 3'b100, 3'b101, 3'b000, 2'b00, 16'b0011_0010_0100_0011, 2'b01};
    tbl[2] = '{3'b101, 3'b001, 3'b011, 3'b100, 2'b01, 16'b0100_0011_0010_0010, 2'b01};
    tbl[3] = '{3'b001, 3'b010, 3'b100, 3'b000, 2'b01, 16'b0010_0000_0000_0011, 2'b00};
    tbl[4] = '{3'b011, 3'b101, 3'b110, 3'b010, 2'b10, 16'b0010_0100_1000_0000, 2'b10};
    tbl[5] = '{3'b100, 3'b000, 3'b001, 3'b101, 2'b00, 16'b0000_0011_0010_0100, 2'b01};
    tbl[6] = '{3'b010, 3'b110, 3'b000, 3'b011, 2'b10, 16'b0000_1000_0011_0010, 2'b10};
    tbl[7] = '{3'b000, 3'b001, 3'b010, 3'b100, 2'b01, 16'b0011_0011_0011_0010, 2'b01};

    set_in(tbl[0].s0, tbl[0].s1, tbl[0].s2, tbl[0].s3, tbl[0].pd);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", outs(), RST_OUT);
    check("reset_state", {18'd0, state_dbg}, {18'd0, RST_STATE});
    #4 rst = 1'b0;
    edges = 0;

`ifdef SEMAFORO_DRIVER_LAMP_TEST_EN
    semaforo3 = 3'b111;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("lamp_test%0d", i), outs(), test_pack(ph_at(edges)));
    end
    check("lamp_test_to_run", {18'd0, state_dbg}, {18'd0, ST_RUN});
`endif

    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3, tbl[i].pd);
      exp_q.push_back({tbl[i].lamps, tbl[i].pl, 1'b0, ph_at(edges + 1)});
      step();
      check($sformatf("row%0d", i), outs(), exp_q.pop_front());
    end

    // VbFb held: lamp2 follows blink_phase
    semaforo2 = 3'b010;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("blink_hold%0d", i), {15'd0, lamp2, blink_phase},
            {15'd0, ph_at(edges) ? 4'b0011 : 4'b0000, ph_at(edges)});
    end

    // V -> Vb on the edge where the phase wraps to 0
    semaforo3 = 3'b011;
    step();
    check("v_before_wrap", {16'd0, lamp3}, {16'd0, 4'b0010});
    for (int i = 0; i < 8 && ((edges + 1) % 8) != 4; i++) begin
      step();
      check("v_hold", {16'd0, lamp3}, {16'd0, 4'b0010});
    end
    semaforo3 = 3'b100;
    step();
    check("vb_at_wrap", {15'd0, lamp3, blink_phase}, {15'd0, 4'b0000, 1'b0});

    // single-cycle illegal pedestrian code
    set_in(3'b000, 3'b011, 3'b101, 3'b110, 2'b11);
    step();
    check("fault_ped", outs(), fault_pack(ph_at(edges)));
    check("fault_state", {18'd0, state_dbg}, {18'd0, ST_FAULT});
    peatonal = 2'b10;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("fault_sticky%0d", i), outs(), fault_pack(ph_at(edges)));
    end

    async_reset("rst_in_fault");

`ifdef SEMAFORO_DRIVER_LAMP_TEST_EN
    for (int i = 0; i < 3; i++) begin
      step();
      check("lamp_test_pre_abort", outs(), test_pack(ph_at(edges)));
    end
    async_reset("rst_in_lamp_test");
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("lamp_test_restart%0d", i), outs(), test_pack(ph_at(edges)));
    end
`else
    set_in(3'b000, 3'b011, 3'b000, 3'b000, 2'b10);
    step();
    check("post_reset_decode", outs(), {16'b0011_0010_0011_0011, 2'b10, 1'b0, 1'b1});
`endif

    // several illegal codes at once behave like one
    set_in(3'b111, 3'b111, 3'b000, 3'b000, 2'b10);
    step();
    check("fault_multi", outs(), fault_pack(ph_at(edges)));
    set_in(3'b000, 3'b000, 3'b000, 3'b000, 2'b00);
    step();
    check("fault_multi_sticky", outs(), fault_pack(ph_at(edges)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
